serial_adder32: RTL and testbench



---
 rtl/serial_adder32.sv | 123 ++++++++++++
 tb/tb_serial_adder32.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder32.sv
// Bit-serial adder: Sum = A + B + Cin, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_ADDER_FLAGS_EN to compute the N/Z/C/V flags; otherwise they are tied to 0.
module serial_adder32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_cnext;
    logic [WIDTH-1:0] w_sum_final;

    assign w_accept    = start && (r_state != S_RUN);
    assign w_last      = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_s         = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cnext     = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_sum_final = {w_s, r_sum[WIDTH-1:1]};

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next == S_RUN);
            done    <= (w_next == S_DONE);
        end
    end

    // Serial datapath; results load only on the last bit step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_c   <= Cin;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_a   <= {1'b0, r_a[WIDTH-1:1]};
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
                r_c   <= w_cnext;
                r_sum <= w_sum_final;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_last) begin
                Sum  <= w_sum_final;
                Cout <= w_cnext;
            end
        end
    end

`ifdef SERIAL_ADDER_FLAGS_EN
    // On the last step r_c is still the carry into the MSB, so V = cin_msb ^ cout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N <= 1'b0;
            Z <= 1'b0;
            C <= 1'b0;
            V <= 1'b0;
        end else if (w_last) begin
            N <= w_sum_final[WIDTH-1];
            Z <= (w_sum_final == '0);
            C <= w_cnext;
            V <= r_c ^ w_cnext;
        end
    end
`else
    assign N = 1'b0;
    assign Z = 1'b0;
    assign C = 1'b0;
    assign V = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder32.sv
// Scoreboard bench for serial_adder32: driver pushes expected results, negedge monitor pops on done.
module tb_serial_adder32;

    localparam int unsigned WIDTH = 32;
`ifdef SERIAL_ADDER_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic [3:0]  nzcv;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [31:0] Sum;
    logic        Cout;
    logic        N;
    logic        Z;
    logic        C;
    logic        V;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    serial_adder32 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout),
        .N(N), .Z(Z), .C(C), .V(V)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every done pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_single_cycle", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sum",     64'(Sum), 64'(mon_e.sum));
                check("cout",    64'(Cout), 64'(mon_e.cout));
                check("nzcv",    64'({N, Z, C, V}), 64'(mon_e.nzcv));
                check("latency", 64'(cyc - mon_e.acc), 64'(WIDTH));
                check("busy_in_done", 64'(busy), 64'd0);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input bit push, input logic [31:0] s, input logic co,
                         input logic [3:0] f, output int acc);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("issue_timeout", 64'd1, 64'd0);
        A = a;
        B = b;
        Cin = cin;
        start = 1'b1;
        acc = cyc + 1;
        if (push) sb.push_back('{s, co, FL ? f : 4'b0, acc});
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = $urandom;
        Cin = ~cin;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  acc;
        bit  bad;
        int  g;

        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({busy, done, Cout, N, Z, C, V}), 64'd0);
        check("reset_sum", 64'(Sum), 64'd0);
        rst_n = 1'b1;

        // Directed vectors: {N,Z,C,V} hand-computed
        issue(32'd5,          32'd3,          1'b0, 1'b1, 32'd8,          1'b0, 4'b0000, acc);
        wait_idle();
        issue(32'h7FFF_FFFF, 32'd1,          1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'b1001, acc);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'd1,          1'b0, 1'b1, 32'h0000_0000, 1'b1, 4'b0110, acc);
        wait_idle();
        issue(32'd0,          32'd0,          1'b1, 1'b1, 32'd1,          1'b0, 4'b0000, acc);
        wait_idle();
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 4'b0000, acc);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 4'b0011, acc);
        wait_idle();

        // Reset mid-operation aborts with no done pulse
        issue(32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0, 4'b0000, acc);
        g = 0;
        while (cyc < acc + 15 && g < 100) begin
            @(negedge clk);
            g++;
        end
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({busy, done, Cout, N, Z, C, V}), 64'd0);
        check("abort_sum", 64'(Sum), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_result", 64'({Sum, done}), 64'd0);
        issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b1, 32'hDFD1_0457, 1'b0, 4'b1000, acc);
        wait_idle();

        // start during RUN is ignored; busy stays high until the final edge
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 4'b0000, acc);
        bad = 1'b0;
        g = 0;
        while (cyc < acc + WIDTH && g < 100) begin
            if (!busy) bad = 1'b1;
            if (cyc == acc + 9) begin
                start = 1'b1;
                A = 32'h0000_FFFF;
                B = 32'h0000_FFFF;
                Cin = 1'b1;
            end
            if (cyc == acc + 10) start = 1'b0;
            @(negedge clk);
            g++;
        end
        check("busy_held", 64'(bad), 64'd0);
        check("busy_drop", 64'({busy, done}), 64'b01);
        wait_idle();
        repeat (40) @(negedge clk);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        A = 32'hFFFF_FFFF;
        B = 32'hFFFF_FFFF;
        Cin = 1'b1;
        start = 1'b1;
        acc = cyc + 1;
        sb.push_back('{32'hFFFF_FFFF, 1'b1, FL ? 4'b1010 : 4'b0000, acc});
        @(negedge clk);
        A = 32'h8000_0000;
        B = 32'h8000_0000;
        Cin = 1'b0;
        g = 0;
        while (cyc < acc + WIDTH && g < 100) begin
            @(negedge clk);
            g++;
        end
        sb.push_back('{32'h0000_0000, 1'b1, FL ? 4'b0111 : 4'b0000, acc + WIDTH + 1});
        @(negedge clk);
        start = 1'b0;
        A = '0;
        B = '0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
